dmem_bus_ctrl: RTL

//  Data-memory bus controller directly downstream of the MEM stage; consumes its dmem_addr/dmem_wd/dmem_we

---
 rtl/dmem_bus_if.sv | 21 ++
 rtl/dmem_bus_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dmem_bus_if.sv
// Valid/ready request channel plus response channel between the MEM-stage bus
// controller (master) and the data memory or interconnect (slave).
interface dmem_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_we,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Turns single-cycle MEM-stage loads/stores into valid/ready bus transactions,
// stalling the pipeline until the response returns or the access errors out.
//
// state | meaning
// IDLE  | no access in flight; an aligned access launches a request
// REQ   | req_valid held with stable payload until req_ready
// WAIT  | request accepted, counting cycles until resp_valid or timeout
// DONE  | one release cycle: stallM low, dmem_rd valid, err_* pulse
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wd,
  input  logic             dmem_we,
  input  logic             dmem_re,
  output logic [31:0]      dmem_rd,
  output logic             stallM,
  output logic             err_misalign,
  output logic             err_timeout,
  dmem_bus_if.master       bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic          req_we_q, req_we_d;
  logic [31:0]   dmem_rd_q, dmem_rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_misalign_q, err_misalign_d;
  logic          err_timeout_q, err_timeout_d;
  logic          stall_c;
  logic          access;

  assign access = dmem_we | dmem_re;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_we_q       <= 1'b0;
      dmem_rd_q      <= '0;
      cnt_q          <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_we_q       <= req_we_d;
      dmem_rd_q      <= dmem_rd_d;
      cnt_q          <= cnt_d;
      err_misalign_q <= err_misalign_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_valid_d    = req_valid_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_we_d       = req_we_q;
    dmem_rd_d      = dmem_rd_q;
    cnt_d          = cnt_q;
    err_misalign_d = 1'b0;
    err_timeout_d  = 1'b0;
    stall_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          if (dmem_addr[1:0] == 2'b00) begin
            req_valid_d = 1'b1;
            req_addr_d  = dmem_addr;
            req_wdata_d = dmem_wd;
            req_we_d    = dmem_we;
            state_d     = REQ;
          end else begin
            err_misalign_d = 1'b1;
            dmem_rd_d      = ERR_DATA;
            state_d        = DONE;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus.req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          // A response arriving with the handshake completes the access directly.
          if (bus.resp_valid) begin
            if (!req_we_q) dmem_rd_d = bus.resp_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (bus.resp_valid) begin
          if (!req_we_q) dmem_rd_d = bus.resp_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          dmem_rd_d     = ERR_DATA;
          err_timeout_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        // The access still presented here is the one just completed.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stallM        = stall_c;
  assign dmem_rd       = dmem_rd_q;
  assign err_misalign  = err_misalign_q;
  assign err_timeout   = err_timeout_q;
  assign bus.req_valid = req_valid_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_we    = req_we_q;

endmodule
